// File: rtl/sprite_bitmap_loader_pkg.sv
// Shared constants, header field positions and FSM state encoding for the
// sprite bitmap loader.
package sprite_bitmap_loader_pkg;

    localparam int unsigned SPR_ROWS  = 16;
    localparam int unsigned SPR_WIDTH = 8;
    localparam int unsigned SPR_ROW_W = 4;

    localparam int unsigned HDR_LEN_MSB = 7;
    localparam int unsigned HDR_LEN_LSB = 4;
    localparam int unsigned HDR_ROW_MSB = 3;
    localparam int unsigned HDR_ROW_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    typedef logic [SPR_ROW_W-1:0] row_idx_t;

endpackage

// File: rtl/sprite_bitmap_loader_if.sv
// Byte-stream valid/ready channel feeding the sprite bitmap loader.
interface sprite_bitmap_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/sprite_bitmap_loader_dbuf.sv
// sprite_dbuf: back/front bitmap register pair with single-row write, bulk
// commit (back->front), bulk restore (front->back) and combinational read.
module sprite_dbuf
    import sprite_bitmap_loader_pkg::*;
#(
    parameter int unsigned ROWS  = SPR_ROWS,
    parameter int unsigned WIDTH = SPR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [SPR_ROW_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 commit_i,
    input  logic                 restore_i,
    input  logic [SPR_ROW_W-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] back_q  [ROWS];
    logic [WIDTH-1:0] front_q [ROWS];

    // Restore discards the whole uncommitted batch, so it wins over a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back_q <= '{default: '0};
        end else if (restore_i) begin
            back_q <= front_q;
        end else if (we_i) begin
            back_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q <= '{default: '0};
        end else if (commit_i) begin
            front_q <= back_q;
        end
    end

    assign rdata_o = front_q[raddr_i];

endmodule

// File: rtl/sprite_bitmap_loader.sv
// Sprite bitmap loader: packet FSM, vsync edge detect and tear-free commit.
// Optional trailer checksum enabled by SPRITE_LOADER_CHECKSUM_EN.
module sprite_bitmap_loader
    import sprite_bitmap_loader_pkg::*;
#(
    parameter int unsigned ROWS  = SPR_ROWS,
    parameter int unsigned WIDTH = SPR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    sprite_bitmap_loader_if.slave  stream,
    input  logic                   vsync,
    input  logic [SPR_ROW_W-1:0]   yofs,
    output logic [WIDTH-1:0]       bits,
    output logic                   busy,
    output logic                   loaded,
    output logic                   cksum_err
);

    state_e     state_q;
    row_idx_t   row_ptr_q;
    logic [3:0] remain_q;
    logic       pending_q;
    logic       vsync_q;
    logic       loaded_q;
    logic       cksum_err_q;

    logic vs_rise;
    logic commit;
    logic xfer;
    logic wr_en;
    logic restore;

    assign vs_rise         = vsync && !vsync_q;
    assign commit          = vs_rise && pending_q && (state_q == ST_IDLE);
    assign stream.in_ready = !commit;
    assign xfer            = stream.in_valid && stream.in_ready;
    assign wr_en           = xfer && (state_q == ST_DATA);

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0] ck_q;
    assign restore = xfer && (state_q == ST_CHECK) && (stream.in_data != ck_q);
`else
    assign restore = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            row_ptr_q   <= '0;
            remain_q    <= '0;
            pending_q   <= 1'b0;
            vsync_q     <= 1'b0;
            loaded_q    <= 1'b0;
            cksum_err_q <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            ck_q        <= '0;
`endif
        end else begin
            vsync_q     <= vsync;
            loaded_q    <= commit;
            cksum_err_q <= 1'b0;
            if (commit) begin
                pending_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        row_ptr_q <= stream.in_data[HDR_ROW_MSB:HDR_ROW_LSB];
                        remain_q  <= stream.in_data[HDR_LEN_MSB:HDR_LEN_LSB];
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        ck_q      <= '0;
`endif
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        row_ptr_q <= row_ptr_q + row_idx_t'(1);
                        remain_q  <= remain_q - 4'd1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        ck_q      <= ck_q ^ stream.in_data;
                        if (remain_q == '0) begin
                            state_q <= ST_CHECK;
                        end
`else
                        if (remain_q == '0) begin
                            state_q   <= ST_IDLE;
                            pending_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_CHECK: begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                    if (xfer) begin
                        state_q <= ST_IDLE;
                        if (restore) begin
                            cksum_err_q <= 1'b1;
                            pending_q   <= 1'b0;
                        end else begin
                            pending_q   <= 1'b1;
                        end
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sprite_dbuf #(
        .ROWS  (ROWS),
        .WIDTH (WIDTH)
    ) u_dbuf (
        .clk       (clk),
        .rst_n     (reset),
        .we_i      (wr_en),
        .waddr_i   (row_ptr_q),
        .wdata_i   (stream.in_data),
        .commit_i  (commit),
        .restore_i (restore),
        .raddr_i   (yofs),
        .rdata_o   (bits)
    );

    assign busy   = (state_q != ST_IDLE);
    assign loaded = loaded_q;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    assign cksum_err = cksum_err_q;
`else
    assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_bitmap_loader.sv
// Scoreboard bench for sprite_bitmap_loader; trailer bytes are added when
// SPRITE_LOADER_CHECKSUM_EN is defined.
module tb_sprite_bitmap_loader;
    import sprite_bitmap_loader_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic [3:0] yofs;
    logic [7:0] bits;
    logic       busy;
    logic       loaded;
    logic       cksum_err;

    sprite_bitmap_loader_if u_if ();

    sprite_bitmap_loader #(
        .ROWS  (16),
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stream    (u_if),
        .vsync     (vsync),
        .yofs      (yofs),
        .bits      (bits),
        .busy      (busy),
        .loaded    (loaded),
        .cksum_err (cksum_err)
    );

    initial forever #5 clk = ~clk;

    typedef enum int {K_BITS, K_READY, K_BUSY} kind_e;
    typedef struct {
        kind_e      kind;
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t exp_q[$];
    int   ld_q[$];
    int   ce_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rd_req   = 1'b0;
    logic mon_en   = 1'b0;

    // Monitor: pops expectations on read strobes and on every output pulse.
    initial begin : monitor
        chk_t       c;
        logic [7:0] act;
        logic       prev_ready;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rd_req) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL scoreboard_empty: read strobe with no expectation queued");
                    end else begin
                        c = exp_q.pop_front();
                        case (c.kind)
                            K_BITS:  act = bits;
                            K_READY: act = {7'd0, u_if.in_ready};
                            default: act = {7'd0, busy};
                        endcase
                        if (act !== c.exp) begin
                            n_fail++;
                            $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                        end
                    end
                end
                if (loaded) begin
                    n_checks++;
                    if (ld_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL loaded_pulse: got 1 expected 0 (no commit due) at %0t", $time);
                    end else begin
                        void'(ld_q.pop_front());
                    end
                end
                if (loaded || !prev_ready) begin
                    n_checks++;
                    if (loaded !== !prev_ready) begin
                        n_fail++;
                        $display("FAIL ready_vs_commit: loaded=%b prev in_ready=%b, required loaded == !prev in_ready",
                                 loaded, prev_ready);
                    end
                end
                if (cksum_err) begin
                    n_checks++;
                    if (ce_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL cksum_err_pulse: got 1 expected 0 at %0t", $time);
                    end else begin
                        void'(ce_q.pop_front());
                    end
                end
                prev_ready = u_if.in_ready;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_vs);
        int   guard;
        logic ok;
        u_if.in_data  = b;
        u_if.in_valid = 1'b1;
        vsync         = with_vs;
        guard         = 0;
        ok            = 1'b0;
        while (!ok && guard < 20) begin
            @(negedge clk);
            ok = u_if.in_ready;
            @(posedge clk);
            #1;
            vsync = 1'b0;
            guard++;
        end
        u_if.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte_timeout: byte %h not accepted, in_ready stayed 0", b);
        end
    endtask

    // Bytes taken MSB-first from d; trailer appended when checksum is built in.
    task automatic send_pkt(input logic [7:0] hdr, input logic [31:0] d, input int n,
                            input logic [7:0] trailer, input logic last_vs);
        logic [7:0] b;
        send_byte(hdr, 1'b0);
        for (int k = 0; k < n; k++) begin
            b = d[31-8*k -: 8];
`ifdef SPRITE_LOADER_CHECKSUM_EN
            send_byte(b, 1'b0);
`else
            send_byte(b, (k == n-1) ? last_vs : 1'b0);
`endif
        end
`ifdef SPRITE_LOADER_CHECKSUM_EN
        send_byte(trailer, last_vs);
`else
        if (trailer == 8'hxx) $display("unused trailer");
`endif
    endtask

    task automatic check(input kind_e k, input logic [3:0] y, input logic [7:0] e, input string name);
        yofs = y;
        exp_q.push_back('{kind: k, exp: e, name: name});
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic row(input logic [3:0] y, input logic [7:0] e, input string tag);
        check(K_BITS, y, e, $sformatf("%s_row%0d", tag, y));
    endtask

    task automatic pulse_vsync(input logic expect_load);
        if (expect_load) ld_q.push_back(1);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        tick();
    endtask

    initial begin : stim
        reset         = 1'b0;
        vsync         = 1'b0;
        yofs          = '0;
        u_if.in_data  = '0;
        u_if.in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;

        for (int y = 0; y < 16; y++) row(4'(y), 8'h00, "reset");
        check(K_READY, 4'd0, 8'd1, "reset_in_ready");
        check(K_BUSY,  4'd0, 8'd0, "reset_busy");

        // Four rows from row 2; nothing visible until vsync.
        send_byte(8'h32, 1'b0);
        check(K_BUSY, 4'd0, 8'd1, "busy_mid_packet");
        send_byte(8'hAA, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h0F, 1'b0);
`ifdef SPRITE_LOADER_CHECKSUM_EN
        check(K_BUSY, 4'd0, 8'd1, "busy_in_check");
        send_byte(8'h0F, 1'b0);
`endif
        check(K_BUSY, 4'd0, 8'd0, "busy_after_packet");
        for (int y = 2; y < 6; y++) row(4'(y), 8'h00, "precommit");
        pulse_vsync(1'b1);
        row(4'd2, 8'hAA, "commit1");
        row(4'd3, 8'h55, "commit1");
        row(4'd4, 8'hFF, "commit1");
        row(4'd5, 8'h0F, "commit1");

        // Row index wraps 15 -> 0.
        send_pkt(8'h1F, 32'h1122_0000, 2, 8'h33, 1'b0);
        pulse_vsync(1'b1);
        row(4'd15, 8'h11, "wrap");
        row(4'd0,  8'h22, "wrap");
        row(4'd2,  8'hAA, "wrap_keep");

        // vsync mid-packet does not commit.
        send_byte(8'hF0, 1'b0);
        for (int k = 0; k < 8; k++) send_byte(8'(8'h80 + k), 1'b0);
        pulse_vsync(1'b0);
        row(4'd0,  8'h22, "midflight");
        row(4'd15, 8'h11, "midflight");
        for (int k = 8; k < 16; k++) send_byte(8'(8'h80 + k), 1'b0);
`ifdef SPRITE_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        pulse_vsync(1'b1);
        for (int y = 0; y < 16; y++) row(4'(y), 8'(8'h80 + y), "full");

        // Final byte coincides with the vsync rise: commit waits one frame.
        send_pkt(8'h01, 32'h5A00_0000, 1, 8'h5A, 1'b1);
        tick();
        row(4'd1, 8'h81, "lastbyte_vs");
        pulse_vsync(1'b1);
        row(4'd1, 8'h5A, "next_vs");
        pulse_vsync(1'b0);
        row(4'd1, 8'h5A, "no_pending");

`ifdef SPRITE_LOADER_CHECKSUM_EN
        send_pkt(8'h10, 32'h0C30_0000, 2, 8'h3C, 1'b0);
        pulse_vsync(1'b1);
        row(4'd0, 8'h0C, "ck_good");
        row(4'd1, 8'h30, "ck_good");
        // A bad trailer discards the good-but-uncommitted packet at row 5 too.
        send_pkt(8'h05, 32'h5500_0000, 1, 8'h55, 1'b0);
        ce_q.push_back(1);
        send_pkt(8'h10, 32'h7766_0000, 2, 8'h00, 1'b0);
        pulse_vsync(1'b0);
        row(4'd0, 8'h0C, "ck_bad");
        row(4'd5, 8'h85, "ck_bad");
        send_pkt(8'h08, 32'h9900_0000, 1, 8'h99, 1'b0);
        pulse_vsync(1'b1);
        row(4'd8, 8'h99, "ck_after");
        row(4'd5, 8'h85, "ck_after");
        row(4'd1, 8'h30, "ck_after");
`endif

        // Reset mid-packet clears both buffers and the FSM.
        send_byte(8'h12, 1'b0);
        send_byte(8'hEE, 1'b0);
        mon_en = 1'b0;
        reset  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
        check(K_BUSY, 4'd0, 8'd0, "rst_mid_busy");
        row(4'd2, 8'h00, "rst_mid");
        row(4'd8, 8'h00, "rst_mid");
        pulse_vsync(1'b0);
        row(4'd2, 8'h00, "rst_mid_vs");

        repeat (3) tick();
        n_checks++;
        if (ld_q.size() != 0) begin
            n_fail++;
            $display("FAIL loaded_missing: got %0d pulses short, expected 0", ld_q.size());
        end
        n_checks++;
        if (ce_q.size() != 0) begin
            n_fail++;
            $display("FAIL cksum_err_missing: got %0d pulses short, expected 0", ce_q.size());
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_bitmap_loader.md
Name: sprite_bitmap_loader

Overview:
- Writer side of the 16x8 sprite bitmap interface.
- Accepts a byte stream over a valid/ready handshake and writes bitmap rows into a back buffer.
- Commits the back buffer to a front buffer only on a vsync rising edge, so the renderer never sees a torn sprite.
- The front buffer drives a combinational row-read port (yofs -> bits) that the sprite renderer consumes.

Parameters:
- ROWS, 16, number of bitmap rows (index width 4).
- WIDTH, 8, bits per row.

Ports:
- clk  input  1  pixel clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts the byte this cycle.
- vsync  input  1  vertical sync, synchronous to clk.
- yofs  input  4  renderer row select.
- bits  output  8  front_buf[yofs], combinational.
- busy  output  1  packet in progress (state != IDLE).
- loaded  output  1  one-cycle pulse in the cycle after a commit.
- cksum_err  output  1  one-cycle pulse on checksum mismatch; constant 0 without the macro.

Behaviour:
- Reset (asserted low, async):
  - front_buf and back_buf all rows 0, so bits = 0.
  - state = IDLE, pending = 0, vsync_q = 0, loaded = 0, cksum_err = 0, in_ready = 1.
- Transfer rule: a byte transfers on a clk edge when in_valid && in_ready.
- Packet format:
  - Header byte: [7:4] = len-1, [3:0] = start_row.
  - Followed by len data bytes (1..16).
  - Data byte k is written to back_buf[(start_row+k) mod 16]; the row index wraps 15 -> 0.
- FSM:
  - IDLE: a transferred header latches row_ptr = start_row and remain = len-1, then goes to DATA.
  - DATA: each transferred byte writes back_buf[row_ptr], row_ptr++ (4-bit wrap), remain--.
  - DATA exit: on the byte with remain == 0, go to IDLE and set pending = 1 (or go to CHECK when the macro is enabled).
  - busy = (state != IDLE).
- Commit:
  - vs_rise = vsync && !vsync_q; vsync_q is registered every cycle.
  - When vs_rise && pending && state == IDLE: front_buf <= back_buf (all rows in one cycle), pending <= 0, and loaded pulses in the following cycle.
  - in_ready = 0 combinationally in the commit cycle; otherwise in_ready = 1.
- Boundary cases:
  - vs_rise while a packet is mid-flight (busy): no commit; the commit defers to the first vs_rise with state == IDLE.
  - Final byte accepted in the same cycle as vs_rise: pending is not yet set, so the commit waits for the next vs_rise.
  - Multiple packets before a vsync: all accumulate in back_buf; one commit shows all of them.
  - vs_rise with pending = 0: no action.
  - vsync high when reset deasserts: counts as a rising edge; this is harmless because pending = 0.
  - Reset mid-packet: packet discarded, both buffers cleared.
- Latency:
  - Row visible on bits 1 cycle after the commit edge.
  - A write is never visible before the next qualifying vsync rise.

Optional Feature:
- Macro: SPRITE_LOADER_CHECKSUM_EN.
- With the macro:
  - Every packet ends with a trailer byte equal to the XOR of all len data bytes.
  - FSM gains a CHECK state, entered after the last data byte.
  - Trailer matches: pending = 1, return to IDLE.
  - Trailer mismatches: cksum_err pulses, back_buf <= front_buf (all rows; this discards the whole uncommitted batch), pending <= 0, return to IDLE.
  - busy stays high in CHECK.
- Without the macro:
  - No trailer byte, no CHECK state.
  - cksum_err is tied to 0.

Decomposition:
- Shared package holds:
  - constants SPR_ROWS = 16, SPR_WIDTH = 8, SPR_ROW_W = 4;
  - header field positions HDR_LEN_MSB/LSB = 7/4 and HDR_ROW_MSB/LSB = 3/0;
  - state encodings ST_IDLE, ST_DATA, ST_CHECK.
- One natural sub-module: sprite_dbuf, the 16x8 back/front register pair with write port, bulk commit, bulk restore and combinational read port.
- The FSM and vsync edge detector live in the top module.

Test Plan:
- Reset, then yofs swept 0..15 -> bits = 0 on every row; in_ready = 1, busy = 0.
- Header 8'h32, data 8'hAA, 8'h55, 8'hFF, 8'h0F, no vsync -> bits unchanged (0) at yofs 2..5. After one vsync rise -> loaded pulses once; yofs 2,3,4,5 read AA, 55, FF, 0F; in_ready = 0 exactly in the commit cycle.
- Header 8'h1F, data 8'h11, 8'h22, then vsync -> row 15 = 11, row 0 = 22 (wrap).
- Header 8'hF0 then 8 of 16 data bytes, vsync rise -> no loaded, front unchanged. Send the remaining 8 bytes, next vsync -> all 16 rows updated.
- Last data byte accepted in the same cycle as vs_rise -> no commit on that edge; commit on the next edge.
- With SPRITE_LOADER_CHECKSUM_EN: header 8'h10, data 8'h0C, 8'h30, trailer 8'h3C -> commit on vsync. Repeat with trailer 8'h00 -> cksum_err pulses, back_buf restored, no loaded on the next vsync.
